// File: rtl/vga_pkg.sv
// Shared VGA timing constants, control-bundle type and counter sizing helper.
package vga_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_ctl_t;

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts ACTIVE+FP+SYNC+BP positions and decodes active/sync regions.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        inc,
  output logic [cnt_width(ACTIVE+FP+SYNC+BP)-1:0]     count,
  output logic                                        wrap,
  output logic                                        in_active,
  output logic                                        in_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int W     = cnt_width(TOTAL);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  assign wrap      = (count == LAST);
  assign in_active = (count < ACT_END);
  assign in_sync   = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + W'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: fetch-side address/request, latency-matched syncs and colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter bit HS_POL     = POL_NEG,
  parameter bit VS_POL     = POL_NEG,
  parameter int CW         = 4,
  parameter int AW         = 32,
  parameter int ADDR_SHIFT = 4,
  parameter int LATENCY    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3*CW-1:0] pixel,
  output logic [AW-1:0]   pixel_addr,
  output logic            pixel_req,
  output logic            h_sync,
  output logic            v_sync,
  output logic            de,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            frame_start,
  output logic            line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int DW      = cnt_width(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam vga_ctl_t      BLANK    = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0};

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CW < 1 || AW < 1 || LATENCY < 0 || LATENCY > 7) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_in_sync, v_in_sync, v_inc;
  logic [AW-1:0] idx;
  vga_ctl_t      fetch_ctl, delayed_ctl;

  assign tick  = (div == DIV_LAST) && en;
  assign v_inc = tick && h_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div <= '0;
    else if (en)
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
  end

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
    .clk(clk), .rst(rst), .inc(tick), .count(h_cnt),
    .wrap(h_wrap), .in_active(h_act), .in_sync(h_in_sync)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
    .clk(clk), .rst(rst), .inc(v_inc), .count(v_cnt),
    .wrap(v_wrap), .in_active(v_act), .in_sync(v_in_sync)
  );

  // idx clears on the last tick of the frame so it reads 0 at h=0,v=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ctl   <= BLANK;
      pixel_addr  <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= tick && (h_cnt == '0);
      if (tick) begin
        fetch_ctl.de <= h_act && v_act;
        fetch_ctl.hs <= h_in_sync ? HS_POL : !HS_POL;
        fetch_ctl.vs <= v_in_sync ? VS_POL : !VS_POL;
        pixel_addr   <= idx << ADDR_SHIFT;
        if (h_wrap && v_wrap)
          idx <= '0;
        else if (h_act && v_act)
          idx <= idx + AW'(1);
      end
    end
  end

  assign pixel_req = fetch_ctl.de;

  if (LATENCY == 0) begin : g_no_delay
    assign delayed_ctl = fetch_ctl;
  end else begin : g_delay
    vga_ctl_t pipe [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < LATENCY; i++)
          pipe[i] <= BLANK;
      end else if (tick) begin
        pipe[0] <= fetch_ctl;
        for (int unsigned i = 1; i < LATENCY; i++)
          pipe[i] <= pipe[i-1];
      end
    end

    assign delayed_ctl = pipe[LATENCY-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync              <= !HS_POL;
      v_sync              <= !VS_POL;
      de                  <= 1'b0;
      {red, green, blue}  <= '0;
    end else if (tick) begin
      h_sync              <= delayed_ctl.hs;
      v_sync              <= delayed_ctl.vs;
      de                  <= delayed_ctl.de;
      {red, green, blue}  <= delayed_ctl.de ? pixel : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster engine; successor to the fixed 640x480 controller.
- Generates hsync, vsync and data-enable from configurable porch/sync timings, with programmable sync polarity and pixel-clock divide.
- Issues a frame-buffer address per active pixel and delays timing by a fixed fetch latency so returned pixel data lines up with the syncs.
- Sits between the frame-buffer memory port and the board VGA DAC pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=1; 1 = every clock)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of h_sync (0 = active-low)
- VS_POL, 0, asserted level of v_sync
- CW, 4, bits per colour channel
- AW, 32, address width
- ADDR_SHIFT, 4, left shift applied to the pixel index (bytes/bits per pixel word)
- LATENCY, 1, pixel ticks from address issue to valid pixel_in (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable; low freezes all counters and pipeline at the current tick
- pixel  in  3*CW  {R,G,B} data for the address issued LATENCY ticks earlier
- pixel_addr  out  AW  frame-buffer address of the pixel being fetched
- pixel_req  out  1  high on ticks where pixel_addr is a valid fetch
- h_sync  out  1  horizontal sync, polarity HS_POL
- v_sync  out  1  vertical sync, polarity VS_POL
- de  out  1  display enable, aligned with colour outputs
- red / green / blue  out  CW each  colour, zero when de low
- frame_start  out  1  one-clock pulse at tick (h=0, v=0) on the fetch side
- line_start  out  1  one-clock pulse at h=0 of every line

Behaviour:
- Reset (async assert, sync release): all counters 0; pixel_addr 0; pixel_req 0; de 0; colours 0; frame_start 0; line_start 0; h_sync = !HS_POL; v_sync = !VS_POL; delay pipeline cleared to the blank state.
- Tick: div counter 0..CLK_DIV-1; tick = (div==CLK_DIV-1) && en. All counters and the pipeline advance only on tick.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active [0,H_ACTIVE), front porch, sync, back porch. Vertical order is the same.
- h wraps H_TOTAL-1 -> 0 and increments v. v wraps V_TOTAL-1 -> 0 at the end of the last line.
- Fetch stage (registered on tick from the current h/v):
  - pixel_req = h<H_ACTIVE && v<V_ACTIVE.
  - pixel_addr = idx << ADDR_SHIFT, where idx counts active pixels from 0; idx resets at h=0,v=0 and increments after each req tick.
  - Last address of the frame is (H_ACTIVE*V_ACTIVE-1)<<ADDR_SHIFT; the next request is 0.
  - frame_start and line_start are asserted for exactly one clock, at the tick where h=0 (and v=0 for frame_start).
- Output stage: raw hs/vs/de are delayed through a LATENCY-deep shift register, one stage per tick.
  - h_sync, v_sync and de are registered from the delayed values.
  - Colours = de_delayed ? pixel : 0, registered.
  - Net: de rises LATENCY+1 ticks after the first pixel_req of a line.
- Outputs hold their values between ticks and while en is low.
- Mid-operation rst: immediate return to reset values; restart begins at h=0,v=0 with a frame_start pulse on the first tick.
- Parameter legality: generate-time check; all widths and porches >=1, LATENCY<=7.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants for 640x480@60 and 800x600@60 (active/porch/sync sets).
  - Polarity localparams.
  - A function computing counter width with clog2 of the totals.
- Sub-module vga_axis_counter: one instance each for horizontal and vertical.
  - Parameters: active/fp/sync/bp.
  - Ports: clk, rst, inc, count, wrap, in_active, in_sync.
  - The vertical instance's inc = tick && h_wrap.

Test Plan:
- Defaults, rst pulse, en=1 -> h_sync low for exactly 384 clks per line; line period 3200 clks; v_sync low for 2 lines (6400 clks); frame period 1,680,000 clks.
- Small config (H 4/1/1/1, V 3/1/1/1, CLK_DIV=1, ADDR_SHIFT=0, LATENCY=2) -> pixel_addr sequence 0..11 then 0; de high 4 ticks per line starting 3 ticks after the first req.
- Same config, pixel = address echo after 2 ticks -> red/green/blue equal the issued index on every de cycle and 0 in blanking.
- HS_POL=1, VS_POL=1 -> syncs idle low, pulse high; widths identical to the first scenario.
- en low for 10 ticks mid-line -> h/v/addr/outputs frozen; resume continues at the same h with no skipped address.
- rst asserted mid-frame at h=200,v=100 -> outputs at reset values within the same clock; after release the first tick produces a frame_start pulse and pixel_addr 0.
